// File: rtl/flex_counter_pkg.sv
// Shared definitions for the multi-channel flexible counter.
// Holds the default channel width and channel count, plus the next-action
// encoding used by each channel to select its next count.
package flex_counter_pkg;

  localparam int DEF_NUM_CNT_BITS = 4;
  localparam int DEF_NUM_CHANNELS = 2;

  // What a channel does to its count on the next edge.
  // WRAP: crosses the boundary (up: to 0, down: to rollover_val).
  // SAT : clamps (up: to rollover_val, down from 0: stays 0,
  //       down from above rollover_val: to rollover_val).
  typedef enum logic [2:0] {
    HOLD = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    INC  = 3'd3,
    DEC  = 3'd4,
    WRAP = 3'd5,
    SAT  = 3'd6
  } cnt_action_t;

endpackage

// File: rtl/flex_counter_chan.sv
// Single counter channel: up/down, wrap or saturate, with clear and load.
// Latency: one cycle from sampled inputs to registered outputs.
// Backpressure: none; every strobe is acted on at the next edge.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   clear, load        clear to 0 / parallel load of load_val
//   count_enable       advance the count this cycle
//   count_down         direction (1 = down)
//   sat_mode           boundary behaviour (1 = saturate, 0 = wrap)
//   rollover_val       terminal value
//   count_out          registered count
//   rollover_flag      registered (count_out == rollover_val at update time)
//   wrap_pulse         one-cycle pulse with the first post-wrap count
module flex_counter_chan
  import flex_counter_pkg::*;
#(
  parameter int W = DEF_NUM_CNT_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_enable,
  input  logic         count_down,
  input  logic         sat_mode,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out,
  output logic         rollover_flag,
  output logic         wrap_pulse
);

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = W'(1);

  cnt_action_t  action;
  logic [W-1:0] next_cnt;

  // Priority: clear > load > count_enable > hold (rst handled in the flop).
  always_comb begin
    action = HOLD;
    if (clear) begin
      action = CLR;
    end else if (load) begin
      action = LOAD;
    end else if (count_enable) begin
      if (!count_down) begin
        // A loaded value above rollover_val is treated as at the boundary.
        if (count_out >= rollover_val) action = sat_mode ? SAT : WRAP;
        else                           action = INC;
      end else begin
        if (count_out == ZERO)             action = sat_mode ? SAT : WRAP;
        else if (count_out > rollover_val) action = SAT;
        else                               action = DEC;
      end
    end
  end

  always_comb begin
    next_cnt = count_out;
    case (action)
      CLR:  next_cnt = ZERO;
      LOAD: next_cnt = load_val;
      INC:  next_cnt = count_out + ONE;
      DEC:  next_cnt = count_out - ONE;
      WRAP: next_cnt = count_down ? rollover_val : ZERO;
      // Down-saturate only reaches SAT at 0 or above rollover_val.
      SAT:  next_cnt = (count_down && count_out == ZERO) ? ZERO : rollover_val;
      default: next_cnt = count_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_out     <= ZERO;
      rollover_flag <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      count_out     <= next_cnt;
      // Flag follows the current rollover_val even while the count holds.
      rollover_flag <= (next_cnt == rollover_val);
      wrap_pulse    <= (action == WRAP);
    end
  end

endmodule

// File: rtl/flex_counter_mc.sv
// Bank of NUM_CHANNELS independent flexible counters sharing one clock.
// Latency: one cycle; all outputs are registers inside each channel.
// Backpressure: none; per-channel strobes are consumed every edge.
// Ports: per-channel vectors are N wide; per-channel values are packed
// N*W wide with channel i at bits [i*W +: W].
module flex_counter_mc
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS-1:0]            clear,
  input  logic [NUM_CHANNELS-1:0]            load,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CHANNELS-1:0]            count_enable,
  input  logic [NUM_CHANNELS-1:0]            count_down,
  input  logic [NUM_CHANNELS-1:0]            sat_mode,
  input  logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CHANNELS*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CHANNELS-1:0]            rollover_flag,
  output logic [NUM_CHANNELS-1:0]            wrap_pulse
);

  localparam int W = NUM_CNT_BITS;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    flex_counter_chan #(
      .W(W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear[i]),
      .load         (load[i]),
      .load_val     (load_val[i*W +: W]),
      .count_enable (count_enable[i]),
      .count_down   (count_down[i]),
      .sat_mode     (sat_mode[i]),
      .rollover_val (rollover_val[i*W +: W]),
      .count_out    (count_out[i*W +: W]),
      .rollover_flag(rollover_flag[i]),
      .wrap_pulse   (wrap_pulse[i])
    );
  end

endmodule

// File: tb/tb_flex_counter_mc.sv
// Bench for flex_counter_mc (W=4, N=2): integer reference model checked
// every cycle, plus directed sequences with literal expected values.
module tb_flex_counter_mc;

  localparam int W = 4;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] clear, load, count_enable, count_down, sat_mode;
  logic [N*W-1:0] load_val, rollover_val;
  logic [N*W-1:0] count_out;
  logic [N-1:0] rollover_flag, wrap_pulse;

  int checks = 0;
  int errors = 0;

  int m_cnt[N];
  int m_flag[N];
  int m_pulse[N];

  always #5 clk = ~clk;

  flex_counter_mc #(.NUM_CNT_BITS(W), .NUM_CHANNELS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_down   (count_down),
    .sat_mode     (sat_mode),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  task automatic chk(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d actual=%0d expected=%0d t=%0t", name, ch, act, exp, $time);
    end
  endtask

  // Reference model: updated from the inputs sampled at each rising edge,
  // then compared against the DUT 1 time unit later.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int c, r, n, w;
      c = m_cnt[i];
      r = int'(rollover_val[i*W +: W]);
      n = c;
      w = 0;
      if (rst) begin
        n = 0;
      end else if (clear[i]) begin
        n = 0;
      end else if (load[i]) begin
        n = int'(load_val[i*W +: W]);
      end else if (count_enable[i]) begin
        if (!count_down[i]) begin
          if (c >= r) begin
            n = sat_mode[i] ? r : 0;
            w = sat_mode[i] ? 0 : 1;
          end else begin
            n = c + 1;
          end
        end else begin
          if (c == 0) begin
            n = sat_mode[i] ? 0 : r;
            w = sat_mode[i] ? 0 : 1;
          end else if (c > r) begin
            n = r;
          end else begin
            n = c - 1;
          end
        end
      end
      m_cnt[i]   = n;
      m_flag[i]  = (!rst && n == r) ? 1 : 0;
      m_pulse[i] = w;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk("model_cnt",   i, int'(count_out[i*W +: W]), m_cnt[i]);
      chk("model_flag",  i, int'(rollover_flag[i]),    m_flag[i]);
      chk("model_pulse", i, int'(wrap_pulse[i]),       m_pulse[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int ch, input int c, input int f, input int p);
    chk({name, "_cnt"},   ch, int'(count_out[ch*W +: W]), c);
    chk({name, "_flag"},  ch, int'(rollover_flag[ch]),    f);
    chk({name, "_pulse"}, ch, int'(wrap_pulse[ch]),       p);
  endtask

  initial begin
    int e39[8];
    int e40[5];
    int e;
    e39 = '{1, 2, 3, 4, 5, 0, 1, 2};
    e40 = '{3, 2, 1, 0, 3};
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_flag[i] = 0; m_pulse[i] = 0;
    end
    rst = 1'b1;
    clear = '0; load = '0; count_enable = '0; count_down = '0; sat_mode = '0;
    load_val = '0;
    rollover_val = {4'd3, 4'd7};
    count_enable = 2'b11;
    tick(); tick();
    lit("reset", 0, 0, 0, 0);
    lit("reset", 1, 0, 0, 0);

    // ch0 up/wrap, rollover 5
    rst = 1'b0;
    count_enable = 2'b01;
    rollover_val = {4'd3, 4'd5};
    for (int k = 0; k < 8; k++) begin
      tick();
      lit("up_wrap", 0, e39[k], (e39[k] == 5) ? 1 : 0, (k == 5) ? 1 : 0);
      lit("up_wrap_other", 1, 0, 0, 0);
    end
    count_enable = '0;
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    lit("clear", 0, 0, 0, 0);

    // ch1 down/wrap, rollover 3
    count_down[1] = 1'b1;
    count_enable[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit("down_wrap", 1, e40[k], (e40[k] == 3) ? 1 : 0, (k == 0 || k == 4) ? 1 : 0);
      lit("down_wrap_other", 0, 0, 0, 0);
    end
    count_enable = '0;

    // ch0 up/sat, rollover 9
    rollover_val[3:0] = 4'd9;
    sat_mode[0] = 1'b1;
    count_enable[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      e = (k < 9) ? k + 1 : 9;
      lit("up_sat", 0, e, (e == 9) ? 1 : 0, 0);
    end
    count_enable = '0;
    sat_mode = '0;

    // load above rollover, then up and down from there
    rollover_val[3:0] = 4'd5;
    load_val[3:0] = 4'd12;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    lit("load_high", 0, 12, 0, 0);
    count_enable[0] = 1'b1;
    tick();
    count_enable[0] = 1'b0;
    lit("high_up", 0, 0, 0, 1);
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    lit("load_high2", 0, 12, 0, 0);
    count_down[0] = 1'b1;
    count_enable[0] = 1'b1;
    tick();
    count_enable[0] = 1'b0;
    count_down[0] = 1'b0;
    lit("high_down", 0, 5, 1, 0);

    // priority: clear beats load and enable; load beats enable
    load_val[3:0] = 4'd4;
    load[0] = 1'b1;
    tick();
    lit("load4", 0, 4, 0, 0);
    clear[0] = 1'b1; load[0] = 1'b1; count_enable[0] = 1'b1;
    load_val[7:4] = 4'd7; load[1] = 1'b1; count_enable[1] = 1'b1;
    tick();
    clear = '0; load = '0; count_enable = '0;
    lit("prio_clear", 0, 0, 0, 0);
    lit("prio_load", 1, 7, 0, 0);

    // reset overrides enable mid-count, with rollover 0
    load_val[3:0] = 4'd7;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    lit("load7", 0, 7, 0, 0);
    rst = 1'b1;
    count_enable[0] = 1'b1;
    rollover_val[3:0] = 4'd0;
    tick();
    lit("rst_mid", 0, 0, 0, 0);
    lit("rst_mid", 1, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("rv0_wrap", 0, 0, 1, 1);
    end
    count_enable = '0;

    // rollover_val change while holding
    rollover_val[3:0] = 4'd3;
    tick();
    lit("rv_change", 0, 0, 0, 0);
    rollover_val[3:0] = 4'd0;
    tick();
    lit("rv_back", 0, 0, 1, 0);

    // mixed stimulus, checked by the model each cycle
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        clear[i]        = ($urandom_range(0, 15) == 0);
        load[i]         = ($urandom_range(0, 9) == 0);
        count_enable[i] = ($urandom_range(0, 3) != 0);
        count_down[i]   = ($urandom_range(0, 1) == 1);
        sat_mode[i]     = ($urandom_range(0, 1) == 1);
        load_val[i*W +: W] = W'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0)
          rollover_val[i*W +: W] = W'($urandom_range(0, 15));
      end
      tick();
    end

    rst = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
